hsv_core_commit_redirect: RTL and testbench
===========================================

# hsv_core_commit_redirect

Commit-side consumer of the execution units' `commit_data_t` stream, sitting between the branch unit's output skid buffer and the register file / fetch unit. It retires beats, performs register writeback, and on a mispredict (`jump`) or misaligned-target trap (`trap`) it broadcasts `flush_req` to all execution units. Once every unit has acknowledged the flush, it redirects fetch to the corrected PC or to the trap vector.

## Interface
Parameters:
- `NUM_UNITS`, default 4: number of execution units receiving `flush_req` and returning `flush_ack`.

Ports:
- `clk_core`  input  1  core clock.
- `rst_core`  input  1  reset; synchronous, active-high.
- `commit_data`  input  `$bits(commit_data_t)`  retiring beat: `jump`, `trap`, `common`, `result`, `next_pc`, `writeback`.
- `valid_i`  input  1  beat valid.
- `ready_o`  output  1  beat accepted when `valid_i & ready_o`.
- `flush_req`  output  1  flush broadcast to all units.
- `flush_ack`  input  `NUM_UNITS`  per-unit acknowledge; may arrive in any cycle after `flush_req` rises.
- `trap_vector`  input  word  trap handler base address, sampled when a trap is accepted.
- `wb_en`  output  1  register write strobe, one cycle.
- `wb_common`  output  `$bits(commit_data.common)`  common fields of the written instruction (destination register).
- `wb_value`  output  word  write value (`result`).
- `redirect_valid`  output  1  fetch redirect request.
- `redirect_pc`  output  word  new fetch PC.
- `redirect_ready`  input  1  fetch accepts the redirect.
- `trap_valid`  output  1  one-cycle pulse when a trap is accepted.
- `trap_pc`  output  word  PC of the faulting instruction.
- `trap_value`  output  word  offending misaligned target (`next_pc`).
- `perf_retired`, `perf_mispredict`, `perf_trap`  output  32 each  event counters (see Configuration).

## Operation
- States `COMMIT_RUN`, `COMMIT_FLUSH`, `COMMIT_REDIRECT`.
- Reset: state `COMMIT_RUN`, ack collector cleared, counters 0. All outputs are 0 except `ready_o`, which is 1.
- `COMMIT_RUN`: `ready_o = 1`. On accept:
  - `trap = 1`: no writeback. Latch `redirect_pc <= trap_vector`, `trap_pc <= common.pc`, `trap_value <= next_pc`, pulse `trap_valid`, go to `COMMIT_FLUSH`. `trap` takes priority over `jump`.
  - else `jump = 1`: writeback if `writeback`, latch `redirect_pc <= next_pc`, go to `COMMIT_FLUSH`.
  - else: writeback if `writeback`, stay in `COMMIT_RUN`.
- `COMMIT_FLUSH`:
  - `ready_o = 0`, `flush_req = 1`.
  - Collector accumulates `seen |= flush_ack` each cycle.
  - When `(seen | flush_ack)` is all ones: clear `seen`, drop `flush_req`, go to `COMMIT_REDIRECT`.
- `COMMIT_REDIRECT`: `ready_o = 0`, `redirect_valid = 1`, `redirect_pc` held stable. On `redirect_ready`, go to `COMMIT_RUN`.
- `flush_ack` is ignored outside `COMMIT_FLUSH`.
- Beats presented outside `COMMIT_RUN` are not accepted; upstream discards them on flush.
- A writeback by the jumping instruction itself always completes, because its link value is architecturally retired.
- Reset mid-flush or mid-redirect: immediate return to reset state. Pending redirect and ack history are lost.

## Timing
- Beat accepted at edge T:
  - `wb_en`, `wb_common` and `wb_value` are valid in cycle T+1. `wb_en` is high for exactly one cycle.
  - `trap_valid` pulses in cycle T+1.
- `flush_req` rises in cycle T+1.
- If all acks are high in cycle T+2, `flush_req` falls and `redirect_valid` rises in cycle T+3.
- Minimum mispredict-to-redirect latency is 3 cycles.
- Zero-wait redirect (`redirect_ready` high in T+3): `ready_o` returns at T+4.
- Non-redirecting beats sustain 1 beat/cycle throughput.

## Configuration
- `HSV_COMMIT_PERF_EN` defined:
  - `perf_retired` increments on every accepted beat.
  - `perf_mispredict` increments on accepted `jump & ~trap`.
  - `perf_trap` increments on accepted `trap`.
  - All three counters are 32-bit, wrap modulo 2^32, and are cleared by reset.
- Not defined: counter logic is absent and all `perf_*` outputs are tied to 0.

## Structure
- Shared package `hsv_core_pkg` holds:
  - `commit_state_t` enum (`COMMIT_RUN`, `COMMIT_FLUSH`, `COMMIT_REDIRECT`).
  - `PERF_CNT_WIDTH = 32`.
  - Existing `commit_data_t` and `word`.
- One sub-module, `hsv_core_commit_flush_ctrl`:
  - Parameterized by `NUM_UNITS`.
  - Inputs `start` and `flush_ack`; outputs `flush_req` and `done`.
  - Owns the `seen` register.
- Top level holds the FSM, writeback registers, redirect/trap registers and counters.

## Test plan
- Three back-to-back plain beats with `writeback = 1` and results `0x11`, `0x22`, `0x33` -> `wb_en` high on three consecutive cycles with matching `wb_value`; `ready_o` never drops.
- Mispredict beat (`jump = 1`, `next_pc = 0x0000_1000`, `writeback = 1`, `result = 0x0000_0F04`), all acks one cycle later, `redirect_ready` high:
  - `wb_value = 0x0F04` at T+1.
  - `redirect_valid` with `redirect_pc = 0x1000` at T+3.
  - `ready_o` high again at T+4.
- Trap beat (`trap = 1`, `jump = 1`, `next_pc = 0x0000_1002`, `trap_vector = 0x8000_0000`) -> `wb_en` stays 0; `trap_valid` pulses with `trap_value = 0x1002`; redirect goes to `0x8000_0000`.
- `NUM_UNITS = 4`, acks arriving staggered (unit 0 at T+2, units 1–2 at T+4, unit 3 at T+6) -> `flush_req` stays high through T+6; `redirect_valid` rises at T+7.
- `redirect_ready` held low for 5 cycles, with `rst_core` asserted in the third -> next cycle shows `COMMIT_RUN` with `redirect_valid = 0`, `ready_o = 1` and counters 0.
- With `HSV_COMMIT_PERF_EN` defined: 10 beats, 2 of them mispredicts and 1 a trap -> `perf_retired = 10`, `perf_mispredict = 2`, `perf_trap = 1`.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: machine word, commit beat layout and commit-stage FSM states.
package hsv_core_pkg;

  typedef logic [31:0] word;

  localparam int PERF_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    COMMIT_RUN,
    COMMIT_FLUSH,
    COMMIT_REDIRECT
  } commit_state_t;

  typedef struct packed {
    word        pc;
    logic [4:0] rd;
  } commit_common_t;

  typedef struct packed {
    logic           jump;
    logic           trap;
    commit_common_t common;
    word            result;
    word            next_pc;
    logic           writeback;
  } commit_data_t;

  localparam int COMMIT_DATA_W = $bits(commit_data_t);
  localparam int COMMON_W      = $bits(commit_common_t);

endpackage

// File: rtl/hsv_core_commit_flush_ctrl.sv
// Flush broadcast and acknowledge collector; done fires once every unit has acked.
module hsv_core_commit_flush_ctrl
#(
  parameter int NUM_UNITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 flush_req,
  output logic                 done
);

  logic [NUM_UNITS-1:0] r_seen;
  logic [NUM_UNITS-1:0] w_merged;

  assign w_merged  = r_seen | flush_ack;
  assign flush_req = start;
  assign done      = start & (&w_merged);

  // Acks outside a flush are dropped so stale history never shortens the next one.
  always_ff @(posedge clk) begin
    if (rst || !start || done) begin
      r_seen <= '0;
    end else begin
      r_seen <= w_merged;
    end
  end

endmodule

// File: rtl/hsv_core_commit_redirect.sv
// Commit stage: retires beats, writes back, flushes and redirects fetch on jump/trap.
// Optional event counters are built when HSV_COMMIT_PERF_EN is defined.
module hsv_core_commit_redirect
  import hsv_core_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic                      clk_core,
  input  logic                      rst_core,
  input  logic [COMMIT_DATA_W-1:0]  commit_data,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      flush_req,
  input  logic [NUM_UNITS-1:0]      flush_ack,
  input  logic [31:0]               trap_vector,
  output logic                      wb_en,
  output logic [COMMON_W-1:0]       wb_common,
  output logic [31:0]               wb_value,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  input  logic                      redirect_ready,
  output logic                      trap_valid,
  output logic [31:0]               trap_pc,
  output logic [31:0]               trap_value,
  output logic [PERF_CNT_WIDTH-1:0] perf_retired,
  output logic [PERF_CNT_WIDTH-1:0] perf_mispredict,
  output logic [PERF_CNT_WIDTH-1:0] perf_trap
);

  commit_data_t  w_beat;
  commit_state_t r_state;
  commit_state_t w_next;
  logic          w_accept;
  logic          w_flush_start;
  logic          w_flush_done;

  logic          r_wb_en;
  logic [COMMON_W-1:0] r_wb_common;
  word           r_wb_value;
  word           r_redirect_pc;
  logic          r_trap_valid;
  word           r_trap_pc;
  word           r_trap_value;

  assign w_beat        = commit_data_t'(commit_data);
  assign w_accept      = valid_i & ready_o;
  assign w_flush_start = (r_state == COMMIT_FLUSH);

  hsv_core_commit_flush_ctrl #(
    .NUM_UNITS (NUM_UNITS)
  ) u_flush_ctrl (
    .clk       (clk_core),
    .rst       (rst_core),
    .start     (w_flush_start),
    .flush_ack (flush_ack),
    .flush_req (flush_req),
    .done      (w_flush_done)
  );

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state <= COMMIT_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    ready_o        = 1'b0;
    redirect_valid = 1'b0;
    case (r_state)
      COMMIT_RUN: begin
        ready_o = 1'b1;
        if (valid_i && (w_beat.trap || w_beat.jump)) begin
          w_next = COMMIT_FLUSH;
        end
      end
      COMMIT_FLUSH: begin
        if (w_flush_done) begin
          w_next = COMMIT_REDIRECT;
        end
      end
      COMMIT_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          w_next = COMMIT_RUN;
        end
      end
      default: w_next = COMMIT_RUN;
    endcase
  end

  // A jump's own link writeback retires; only a trap suppresses it.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_wb_en       <= 1'b0;
      r_wb_common   <= '0;
      r_wb_value    <= '0;
      r_trap_valid  <= 1'b0;
      r_redirect_pc <= '0;
      r_trap_pc     <= '0;
      r_trap_value  <= '0;
    end else begin
      r_wb_en      <= w_accept & ~w_beat.trap & w_beat.writeback;
      r_trap_valid <= w_accept & w_beat.trap;
      if (w_accept) begin
        r_wb_common <= w_beat.common;
        r_wb_value  <= w_beat.result;
      end
      if (w_accept && w_beat.trap) begin
        r_redirect_pc <= trap_vector;
        r_trap_pc     <= w_beat.common.pc;
        r_trap_value  <= w_beat.next_pc;
      end else if (w_accept && w_beat.jump) begin
        r_redirect_pc <= w_beat.next_pc;
      end
    end
  end

  assign wb_en       = r_wb_en;
  assign wb_common   = r_wb_common;
  assign wb_value    = r_wb_value;
  assign redirect_pc = r_redirect_pc;
  assign trap_valid  = r_trap_valid;
  assign trap_pc     = r_trap_pc;
  assign trap_value  = r_trap_value;

`ifdef HSV_COMMIT_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] r_perf_retired;
  logic [PERF_CNT_WIDTH-1:0] r_perf_mispredict;
  logic [PERF_CNT_WIDTH-1:0] r_perf_trap;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_perf_retired    <= '0;
      r_perf_mispredict <= '0;
      r_perf_trap       <= '0;
    end else if (w_accept) begin
      r_perf_retired <= r_perf_retired + 1'b1;
      if (w_beat.trap) begin
        r_perf_trap <= r_perf_trap + 1'b1;
      end else if (w_beat.jump) begin
        r_perf_mispredict <= r_perf_mispredict + 1'b1;
      end
    end
  end

  assign perf_retired    = r_perf_retired;
  assign perf_mispredict = r_perf_mispredict;
  assign perf_trap       = r_perf_trap;
`else
  assign perf_retired    = '0;
  assign perf_mispredict = '0;
  assign perf_trap       = '0;
`endif

endmodule

// File: tb/tb_hsv_core_commit_redirect.sv
// Directed bench for hsv_core_commit_redirect with a writeback scoreboard.
module tb_hsv_core_commit_redirect;
  import hsv_core_pkg::*;

  localparam int NUM_UNITS = 4;

  logic                      clk_core = 1'b0;
  logic                      rst_core;
  logic [COMMIT_DATA_W-1:0]  commit_data;
  logic                      valid_i;
  logic                      ready_o;
  logic                      flush_req;
  logic [NUM_UNITS-1:0]      flush_ack;
  logic [31:0]               trap_vector;
  logic                      wb_en;
  logic [COMMON_W-1:0]       wb_common;
  logic [31:0]               wb_value;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic                      redirect_ready;
  logic                      trap_valid;
  logic [31:0]               trap_pc;
  logic [31:0]               trap_value;
  logic [PERF_CNT_WIDTH-1:0] perf_retired;
  logic [PERF_CNT_WIDTH-1:0] perf_mispredict;
  logic [PERF_CNT_WIDTH-1:0] perf_trap;

  int assertCount = 0;
  int failCount   = 0;
  logic [COMMON_W+31:0] sbQ[$];

  always #5 clk_core = ~clk_core;

  hsv_core_commit_redirect #(.NUM_UNITS(NUM_UNITS)) dut (
    .clk_core        (clk_core),
    .rst_core        (rst_core),
    .commit_data     (commit_data),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .flush_req       (flush_req),
    .flush_ack       (flush_ack),
    .trap_vector     (trap_vector),
    .wb_en           (wb_en),
    .wb_common       (wb_common),
    .wb_value        (wb_value),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
    .trap_valid      (trap_valid),
    .trap_pc         (trap_pc),
    .trap_value      (trap_value),
    .perf_retired    (perf_retired),
    .perf_mispredict (perf_mispredict),
    .perf_trap       (perf_trap)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk_core);
    #1;
  endtask

  task automatic applyStimulus(input logic jump, input logic trap, input word pc,
                               input logic [4:0] rd, input word result,
                               input word nextPc, input logic wb);
    commit_data_t b;
    b.jump          = jump;
    b.trap          = trap;
    b.common.pc     = pc;
    b.common.rd     = rd;
    b.result        = result;
    b.next_pc       = nextPc;
    b.writeback     = wb;
    commit_data     = b;
    valid_i         = 1'b1;
    if (wb && !trap) sbQ.push_back({b.common, result});
  endtask

  // Jump/trap beat with all acks at T+2 and zero-wait redirect acceptance.
  task automatic runRedirect(input logic jump, input logic trap, input word nextPc, input word expPc);
    applyStimulus(jump, trap, 32'h0000_4000, 5'd3, 32'h0000_00AA, nextPc, 1'b1);
    stepClk();
    valid_i = 1'b0;
    checkOutput("rdFlushReq", flush_req, 1);
    stepClk();
    flush_ack      = '1;
    redirect_ready = 1'b1;
    stepClk();
    flush_ack = '0;
    checkOutput("rdValid", redirect_valid, 1);
    checkOutput("rdPc", redirect_pc, expPc);
    stepClk();
    redirect_ready = 1'b0;
    checkOutput("rdReadyBack", ready_o, 1);
  endtask

  always @(negedge clk_core) begin
    if (wb_en) begin
      logic [COMMON_W+31:0] e;
      checkOutput("sbWbExpected", sbQ.size() > 0, 1);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("sbWbValue", wb_value, e[31:0]);
        checkOutput("sbWbCommon", wb_common, e[COMMON_W+31:32]);
      end
    end
  end

  initial begin
    rst_core       = 1'b1;
    valid_i        = 1'b0;
    commit_data    = '0;
    flush_ack      = '0;
    trap_vector    = 32'h8000_0000;
    redirect_ready = 1'b0;
    stepClk();
    stepClk();
    checkOutput("rstReady", ready_o, 1);
    checkOutput("rstFlushReq", flush_req, 0);
    checkOutput("rstWbEn", wb_en, 0);
    checkOutput("rstRedirect", redirect_valid, 0);
    checkOutput("rstRedirectPc", redirect_pc, 0);
    checkOutput("rstTrapValid", trap_valid, 0);
    checkOutput("rstPerf", {perf_retired, perf_mispredict | perf_trap}, 0);
    rst_core = 1'b0;
    stepClk();

    $display("[TB] back-to-back plain beats");
    applyStimulus(1'b0, 1'b0, 32'h100, 5'd1, 32'h11, 32'h104, 1'b1);
    stepClk();
    checkOutput("plainWb1", {wb_en, wb_value}, {1'b1, 32'h11});
    checkOutput("plainReady1", ready_o, 1);
    applyStimulus(1'b0, 1'b0, 32'h104, 5'd2, 32'h22, 32'h108, 1'b1);
    stepClk();
    checkOutput("plainWb2", {wb_en, wb_value}, {1'b1, 32'h22});
    checkOutput("plainReady2", ready_o, 1);
    applyStimulus(1'b0, 1'b0, 32'h108, 5'd3, 32'h33, 32'h10C, 1'b1);
    stepClk();
    checkOutput("plainWb3", {wb_en, wb_value}, {1'b1, 32'h33});
    checkOutput("plainReady3", ready_o, 1);
    valid_i = 1'b0;
    stepClk();
    checkOutput("plainWbPulse", wb_en, 0);

    $display("[TB] mispredict");
    applyStimulus(1'b1, 1'b0, 32'h200, 5'd1, 32'h0000_0F04, 32'h0000_1000, 1'b1);
    stepClk();
    valid_i = 1'b0;
    checkOutput("mpWb", {wb_en, wb_value}, {1'b1, 32'h0F04});
    checkOutput("mpFlushReqT1", flush_req, 1);
    checkOutput("mpReadyT1", ready_o, 0);
    stepClk();
    checkOutput("mpFlushReqT2", flush_req, 1);
    checkOutput("mpNoRedirectT2", redirect_valid, 0);
    flush_ack      = '1;
    redirect_ready = 1'b1;
    stepClk();
    flush_ack = '0;
    checkOutput("mpFlushDropT3", flush_req, 0);
    checkOutput("mpRedirectT3", {redirect_valid, redirect_pc}, {1'b1, 32'h1000});
    checkOutput("mpReadyT3", ready_o, 0);
    stepClk();
    redirect_ready = 1'b0;
    checkOutput("mpReadyT4", {ready_o, redirect_valid}, {1'b1, 1'b0});

    $display("[TB] trap");
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 5'd4, 32'h55, 32'h0000_1002, 1'b1);
    stepClk();
    valid_i     = 1'b0;
    trap_vector = 32'h1234_0000;
    checkOutput("trapNoWb", wb_en, 0);
    checkOutput("trapPulse", trap_valid, 1);
    checkOutput("trapValue", trap_value, 32'h1002);
    checkOutput("trapPc", trap_pc, 32'h2000);
    stepClk();
    checkOutput("trapPulseOnce", trap_valid, 0);
    flush_ack      = '1;
    redirect_ready = 1'b1;
    stepClk();
    flush_ack = '0;
    checkOutput("trapRedirect", {redirect_valid, redirect_pc}, {1'b1, 32'h8000_0000});
    stepClk();
    redirect_ready = 1'b0;
    checkOutput("trapReadyBack", ready_o, 1);

    $display("[TB] staggered acks, stale acks in RUN");
    flush_ack = '1;
    stepClk();
    flush_ack = '0;
    applyStimulus(1'b1, 1'b0, 32'h300, 5'd0, 32'h0, 32'h0000_3000, 1'b0);
    stepClk();
    valid_i = 1'b0;
    checkOutput("stgFlushT1", flush_req, 1);
    stepClk();
    flush_ack = 4'b0001;
    stepClk();
    flush_ack = '0;
    checkOutput("stgFlushT3", flush_req, 1);
    stepClk();
    flush_ack = 4'b0110;
    stepClk();
    flush_ack = '0;
    checkOutput("stgFlushT5", {flush_req, redirect_valid}, {1'b1, 1'b0});
    stepClk();
    flush_ack = 4'b1000;
    checkOutput("stgFlushT6", flush_req, 1);
    stepClk();
    flush_ack = '0;
    checkOutput("stgRedirectT7", {flush_req, redirect_valid, redirect_pc}, {1'b0, 1'b1, 32'h3000});

    $display("[TB] reset during redirect wait");
    stepClk();
    checkOutput("holdRedirect", redirect_valid, 1);
    stepClk();
    rst_core = 1'b1;
    stepClk();
    rst_core = 1'b0;
    checkOutput("midRstState", dut.r_state, COMMIT_RUN);
    checkOutput("midRstRedirect", {redirect_valid, redirect_pc}, 0);
    checkOutput("midRstReady", ready_o, 1);
    checkOutput("midRstPerf", {perf_retired, perf_mispredict | perf_trap}, 0);

    $display("[TB] counter run");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h500 + 4 * i, 5'(i), 32'h700 + i, 32'h504 + 4 * i, 1'(i % 2));
      stepClk();
    end
    runRedirect(1'b1, 1'b0, 32'h0000_6000, 32'h0000_6000);
    runRedirect(1'b1, 1'b0, 32'h0000_6100, 32'h0000_6100);
    trap_vector = 32'h9000_0000;
    runRedirect(1'b0, 1'b1, 32'h0000_6201, 32'h9000_0000);
`ifdef HSV_COMMIT_PERF_EN
    checkOutput("perfRetired", perf_retired, 10);
    checkOutput("perfMispredict", perf_mispredict, 2);
    checkOutput("perfTrap", perf_trap, 1);
`else
    checkOutput("perfRetiredOff", perf_retired, 0);
    checkOutput("perfMispredictOff", perf_mispredict, 0);
    checkOutput("perfTrapOff", perf_trap, 0);
`endif

    stepClk();
    stepClk();
    checkOutput("sbDrained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
